// File: rtl/me_result_packer_if.sv
// Lane-result inputs, packed output stream and status flags of me_result_packer.
// slave = packer side, master = environment (ME core lanes + stream consumer).
interface me_result_packer_if #(
  parameter int BLK_IDX_W = 15
);
  logic                    finish_a_cur0;
  logic [3:0]              mv_x0;
  logic [3:0]              mv_y0;
  logic [13:0]             min_sad0;
  logic                    finish_a_cur1;
  logic [3:0]              mv_x1;
  logic [3:0]              mv_y1;
  logic [13:0]             min_sad1;
  logic                    out_valid;
  logic                    out_ready;
  logic [BLK_IDX_W+21:0]   out_data;
  logic                    frame_done;
  logic                    overflow;

  modport slave (
    input  finish_a_cur0, mv_x0, mv_y0, min_sad0,
    input  finish_a_cur1, mv_x1, mv_y1, min_sad1,
    input  out_ready,
    output out_valid, out_data, frame_done, overflow
  );

  modport master (
    output finish_a_cur0, mv_x0, mv_y0, min_sad0,
    output finish_a_cur1, mv_x1, mv_y1, min_sad1,
    output out_ready,
    input  out_valid, out_data, frame_done, overflow
  );
endinterface

// File: rtl/me_result_packer.sv
// Restores raster order of dual-lane ME results and streams packed words through a FIFO.
// Optional frame SAD total on sad_sum when ME_RESULT_SADSUM_EN is defined.
module me_result_packer #(
  parameter int NUM_BLKS   = 32400,
  parameter int BLK_IDX_W  = 15,
  parameter int FIFO_DEPTH = 8
) (
  input logic               clk,
  input logic               rst,
  me_result_packer_if.slave bus
`ifdef ME_RESULT_SADSUM_EN
  ,
  output logic [29:0]       sad_sum
`endif
);
  localparam int RES_W  = 22;
  localparam int DATA_W = BLK_IDX_W + RES_W;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = AW + 1;
  localparam logic [BLK_IDX_W-1:0] LAST_IDX = BLK_IDX_W'(NUM_BLKS - 1);

  logic [1:0]             pulse;
  logic [RES_W-1:0]       lane_res [2];
  logic [RES_W-1:0]       hold_data [2];
  logic [1:0]             hold_v;
  logic [1:0]             drain;
  logic [1:0]             ovf_evt;

  logic                   exp_lane_reg;
  logic [BLK_IDX_W-1:0]   wr_idx_reg;
  logic [BLK_IDX_W-1:0]   rd_idx_reg;
  logic [PTR_W-1:0]       wr_ptr_reg;
  logic [PTR_W-1:0]       rd_ptr_reg;
  logic [PTR_W-1:0]       wr_ptr_next;
  logic [PTR_W-1:0]       rd_ptr_next;
  logic [DATA_W-1:0]      mem [FIFO_DEPTH];
  logic [DATA_W-1:0]      wr_word;
  logic [DATA_W-1:0]      out_data_reg;
  logic                   out_valid_reg;
  logic                   frame_done_reg;
  logic                   overflow_reg;
  logic                   full;
  logic                   push;
  logic                   pop;

  assign pulse       = {bus.finish_a_cur1, bus.finish_a_cur0};
  assign lane_res[0] = {bus.mv_x0, bus.mv_y0, bus.min_sad0};
  assign lane_res[1] = {bus.mv_x1, bus.mv_y1, bus.min_sad1};

  assign full = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop  = out_valid_reg & bus.out_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept a push.
  assign push = hold_v[exp_lane_reg] & (~full | pop);

  assign wr_word     = {wr_idx_reg, hold_data[exp_lane_reg]};
  assign wr_ptr_next = push ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
  assign rd_ptr_next = pop  ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic [RES_W-1:0] res_reg;
      logic             v_reg;

      assign drain[gi]   = push && (exp_lane_reg == 1'(gi));
      // Overrun only when the hold is still occupied after this edge.
      assign ovf_evt[gi] = pulse[gi] && v_reg && !drain[gi];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          res_reg <= '0;
          v_reg   <= 1'b0;
        end else if (pulse[gi] && !ovf_evt[gi]) begin
          res_reg <= lane_res[gi];
          v_reg   <= 1'b1;
        end else if (drain[gi]) begin
          v_reg   <= 1'b0;
        end
      end

      assign hold_data[gi] = res_reg;
      assign hold_v[gi]    = v_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_word;
    end
  end

  // Head register: bypass the word being written when it lands in the next head slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_reg <= '0;
    end else if (push && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0])) begin
      out_data_reg <= wr_word;
    end else if (wr_ptr_next != rd_ptr_next) begin
      out_data_reg <= mem[rd_ptr_next[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      out_valid_reg  <= 1'b0;
      exp_lane_reg   <= 1'b0;
      wr_idx_reg     <= '0;
      rd_idx_reg     <= '0;
      frame_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      out_valid_reg  <= (wr_ptr_next != rd_ptr_next);
      overflow_reg   <= overflow_reg | (|ovf_evt);
      frame_done_reg <= pop && (rd_idx_reg == LAST_IDX);
      if (push) begin
        // Frame wrap restarts on lane0 so odd block counts stay aligned.
        if (wr_idx_reg == LAST_IDX) begin
          wr_idx_reg   <= '0;
          exp_lane_reg <= 1'b0;
        end else begin
          wr_idx_reg   <= wr_idx_reg + BLK_IDX_W'(1);
          exp_lane_reg <= ~exp_lane_reg;
        end
      end
      if (pop) begin
        if (rd_idx_reg == LAST_IDX) begin
          rd_idx_reg <= '0;
        end else begin
          rd_idx_reg <= rd_idx_reg + BLK_IDX_W'(1);
        end
      end
    end
  end

`ifdef ME_RESULT_SADSUM_EN
  logic [29:0] acc_reg;
  logic [29:0] sad_sum_reg;
  logic [29:0] acc_next;

  assign acc_next = acc_reg + 30'(out_data_reg[13:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg     <= '0;
      sad_sum_reg <= '0;
    end else if (pop) begin
      if (rd_idx_reg == LAST_IDX) begin
        sad_sum_reg <= acc_next;
        acc_reg     <= '0;
      end else begin
        acc_reg     <= acc_next;
      end
    end
  end

  assign sad_sum = sad_sum_reg;
`endif

  assign bus.out_valid  = out_valid_reg;
  assign bus.out_data   = out_data_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.overflow   = overflow_reg;
endmodule

// File: tb/tb_me_result_packer.sv
// Directed bench for me_result_packer: default instance plus a NUM_BLKS=5 instance for frame wrap.
// Both instances see the same stimulus; each test checks the instance it targets.
module tb_me_result_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        f0 = 1'b0, f1 = 1'b0, rdy = 1'b0;
  logic [3:0]  mx0 = '0, my0 = '0, mx1 = '0, my1 = '0;
  logic [13:0] s0 = '0, s1 = '0;
  int          n_chk = 0;
  int          n_err = 0;
  int          fd5_cnt = 0;
  int          waited;
`ifdef ME_RESULT_SADSUM_EN
  logic [29:0] sad_sum;
  logic [29:0] sad_sum5;
`endif

  always #5 clk = ~clk;

  me_result_packer_if #(.BLK_IDX_W(15)) bus ();
  me_result_packer_if #(.BLK_IDX_W(15)) bus5 ();

  assign bus.finish_a_cur0  = f0;
  assign bus.mv_x0          = mx0;
  assign bus.mv_y0          = my0;
  assign bus.min_sad0       = s0;
  assign bus.finish_a_cur1  = f1;
  assign bus.mv_x1          = mx1;
  assign bus.mv_y1          = my1;
  assign bus.min_sad1       = s1;
  assign bus.out_ready      = rdy;
  assign bus5.finish_a_cur0 = f0;
  assign bus5.mv_x0         = mx0;
  assign bus5.mv_y0         = my0;
  assign bus5.min_sad0      = s0;
  assign bus5.finish_a_cur1 = f1;
  assign bus5.mv_x1         = mx1;
  assign bus5.mv_y1         = my1;
  assign bus5.min_sad1      = s1;
  assign bus5.out_ready     = rdy;

  me_result_packer dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus)
`ifdef ME_RESULT_SADSUM_EN
    ,
    .sad_sum (sad_sum)
`endif
  );

  me_result_packer #(.NUM_BLKS(5)) dut5 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus5)
`ifdef ME_RESULT_SADSUM_EN
    ,
    .sad_sum (sad_sum5)
`endif
  );

  always @(negedge clk) begin
    if (bus5.frame_done) fd5_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [36:0] word(input int idx, input logic [3:0] x,
                                       input logic [3:0] y, input logic [13:0] sad);
    logic [14:0] i15;
    i15 = 15'(idx);
    return {i15, x, y, sad};
  endfunction

  task automatic do_reset();
    f0 = 1'b0;
    f1 = 1'b0;
    rdy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // One-cycle strobe on the lanes selected by mask; returns at the following negedge.
  task automatic pulse(input logic [1:0] mask, input logic [3:0] x, input logic [3:0] y,
                       input logic [13:0] sad, input logic [13:0] sad1);
    f0 = mask[0]; mx0 = x; my0 = y; s0 = sad;
    f1 = mask[1]; mx1 = x; my1 = y; s1 = sad1;
    @(negedge clk);
    f0 = 1'b0;
    f1 = 1'b0;
  endtask

  // Waits (bounded) for out_valid on the chosen instance and checks the head word.
  task automatic get_word(input string tag, input bit sel, input logic [36:0] exp,
                          output int w);
    logic        v;
    logic [36:0] d;
    w = -1;
    v = 1'b0;
    for (int i = 0; i < 20; i++) begin
      v = sel ? bus5.out_valid : bus.out_valid;
      if (v) begin
        d = sel ? bus5.out_data : bus.out_data;
        w = i;
        check(tag, 64'(d), 64'(exp));
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    check({tag, "_valid_timeout"}, 64'(v), 64'(1'b1));
  endtask

  initial begin
    // Reset state, sampled while reset is held.
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data", 64'(bus.out_data), 64'(0));
    check("rst_frame_done", 64'(bus.frame_done), 64'(0));
    check("rst_overflow", 64'(bus.overflow), 64'(0));
`ifdef ME_RESULT_SADSUM_EN
    check("rst_sad_sum", 64'(sad_sum), 64'(0));
`endif

    // Single block: two-cycle latency.
    do_reset();
    rdy = 1'b1;
    pulse(2'b01, 4'd3, 4'd5, 14'd100, 14'd0);
    check("t1_valid_k", 64'(bus.out_valid), 64'(0));
    @(negedge clk);
    check("t1_valid_k1", 64'(bus.out_valid), 64'(1));
    check("t1_data", 64'(bus.out_data), 64'(word(0, 4'd3, 4'd5, 14'd100)));
    @(negedge clk);
    check("t1_drained", 64'(bus.out_valid), 64'(0));

    // Both lanes on the same edge: lane0 first, back-to-back.
    do_reset();
    rdy = 1'b1;
    pulse(2'b11, 4'd1, 4'd2, 14'd10, 14'd20);
    get_word("t2_w0", 1'b0, word(0, 4'd1, 4'd2, 14'd10), waited);
    get_word("t2_w1", 1'b0, word(1, 4'd1, 4'd2, 14'd20), waited);
    check("t2_back2back", 64'(waited), 64'(0));

    // Lane1 early: must wait for lane0.
    do_reset();
    rdy = 1'b1;
    pulse(2'b10, 4'd2, 4'd2, 14'd0, 14'd7);
    repeat (4) @(negedge clk);
    check("t3_wait_lane0", 64'(bus.out_valid), 64'(0));
    pulse(2'b01, 4'd6, 4'd1, 14'd9, 14'd0);
    get_word("t3_w0", 1'b0, word(0, 4'd6, 4'd1, 14'd9), waited);
    get_word("t3_w1", 1'b0, word(1, 4'd2, 4'd2, 14'd7), waited);
    check("t3_overflow", 64'(bus.overflow), 64'(0));

    // Back-pressure: 8 in FIFO, 2 in holds, 11th pulse overruns hold0.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      pulse((i % 2 == 0) ? 2'b01 : 2'b10, 4'(i), 4'(15 - i), 14'(100 + i), 14'(100 + i));
    end
    repeat (2) @(negedge clk);
    check("t4_no_ovf_yet", 64'(bus.overflow), 64'(0));
    check("t4_head_valid", 64'(bus.out_valid), 64'(1));
    check("t4_head_data", 64'(bus.out_data), 64'(word(0, 4'd0, 4'd15, 14'd100)));
    pulse(2'b01, 4'd9, 4'd9, 14'd999, 14'd0);
    check("t4_overflow", 64'(bus.overflow), 64'(1));
    rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      get_word($sformatf("t4_w%0d", i), 1'b0, word(i, 4'(i), 4'(15 - i), 14'(100 + i)), waited);
    end
    repeat (3) @(negedge clk);
    check("t4_dropped", 64'(bus.out_valid), 64'(0));
    check("t4_sticky", 64'(bus.overflow), 64'(1));

    // Frame wrap on the NUM_BLKS=5 instance: lanes 0,1,0,1,0 then 0,1.
    do_reset();
    rdy = 1'b1;
    fd5_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      logic [1:0] m;
      int         idx;
      m   = (i == 1 || i == 3 || i == 6) ? 2'b10 : 2'b01;
      idx = (i < 5) ? i : i - 5;
      pulse(m, 4'(i), 4'(i + 1), 14'(i + 1), 14'(i + 1));
      get_word($sformatf("t5_w%0d", i), 1'b1, word(idx, 4'(i), 4'(i + 1), 14'(i + 1)), waited);
      if (i == 3) check("t5_no_done_early", 64'(bus5.frame_done), 64'(0));
      if (i == 4) begin
        check("t5_frame_done", 64'(bus5.frame_done), 64'(1));
`ifdef ME_RESULT_SADSUM_EN
        check("t5_sad_sum", 64'(sad_sum5), 64'(15));
`endif
      end
    end
    repeat (2) @(negedge clk);
    check("t5_done_count", 64'(fd5_cnt), 64'(1));
    check("t5_overflow", 64'(bus5.overflow), 64'(0));

    // Reset mid-stream drops buffered words.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pulse((i % 2 == 0) ? 2'b01 : 2'b10, 4'd4, 4'd4, 14'(50 + i), 14'(50 + i));
    end
    repeat (2) @(negedge clk);
    check("t6_buffered", 64'(bus.out_valid), 64'(1));
    rst = 1'b0;
    #1;
    check("t6_async_clear", 64'(bus.out_valid), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    rdy = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_empty_after", 64'(bus.out_valid), 64'(0));
    pulse(2'b01, 4'd7, 4'd8, 14'd77, 14'd0);
    get_word("t6_first_idx0", 1'b0, word(0, 4'd7, 4'd8, 14'd77), waited);
    check("t6_no_done", 64'(bus.frame_done), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
